// File: rtl/cnt_int_ctrl.sv
// cnt_int_ctrl: two periodic timers plus a synchronized external edge source feeding one interrupt request FSM
// Ports:
//   clk, reset (async active-low)
//   stallE, cnt_intE, cnt_int_selE, cnt_int_disableE, cnt_valE : counter-interrupt command from E stage
//   ext_int     : asynchronous external (gun trigger) input
//   int_ack     : pipeline took the interrupt
//   rti_valid   : rti retired (stall-qualified)
//   whatint_rd  : whatint reading the cause word
//   int_req     : interrupt request, high only in REQ
//   int_cause   : {cause[1:0], 14'b0, missed[7:0], 5'b0, pending[2:0]}
//   in_service  : handler running
// Optional: define CNT_INT_MISSED_EN for per-timer saturating missed-tick counters in int_cause[15:8].
// SYNC_STAGES must be at least 2.
module cnt_int_ctrl #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallE,
  input  logic             cnt_intE,
  input  logic             cnt_int_selE,
  input  logic             cnt_int_disableE,
  input  logic [CNT_W-1:0] cnt_valE,
  input  logic             ext_int,
  input  logic             int_ack,
  input  logic             rti_valid,
  input  logic             whatint_rd,
  output logic             int_req,
  output logic [31:0]      int_cause,
  output logic             in_service
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  localparam logic [CNT_W-1:0] cnt_one = CNT_W'(1);
  state_t                  state_q, state_d;
  logic [1:0]              cause_q, cause_d;
  logic [1:0][CNT_W-1:0]   period_q, period_d, count_q, count_d;
  logic [1:0]              en_q, en_d;
  logic [2:0]              pend_q, pend_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    ext_prev_q, ext_prev_d;
  logic [1:0]              cmd_hit, cmd_load, tick;
  logic [2:0]              pend_clr;
  logic                    ext_edge, cause_pend;
  logic [7:0]              missed_sel;
  // A load with a zero period is treated as a disable.
  always_comb begin
    cmd_hit  = (cnt_intE & ~stallE) ? (cnt_int_selE ? 2'b10 : 2'b01) : 2'b00;
    cmd_load = cmd_hit & {2{~cnt_int_disableE & |cnt_valE}};
  end
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], ext_int};
    ext_prev_d = sync_q[SYNC_STAGES-1];
    ext_edge   = sync_q[SYNC_STAGES-1] & ~ext_prev_q;
  end
  // Count runs 0..period-1; the tick fires on the last value, so the first
  // tick lands exactly `period` cycles after the load cycle. Commands win over ticks.
  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    en_d     = en_q;
    tick     = '0;
    for (int i = 0; i < 2; i++) begin
      tick[i] = en_q[i] & (count_q[i] + cnt_one == period_q[i]);
      if (cmd_hit[i]) begin
        en_d[i]    = cmd_load[i];
        count_d[i] = '0;
        if (cmd_load[i]) period_d[i] = cnt_valE;
      end else if (en_q[i]) begin
        count_d[i] = tick[i] ? '0 : count_q[i] + cnt_one;
      end
    end
  end
  // New events override same-cycle clears so a tick coinciding with rti is not lost.
  always_comb begin
    pend_clr = '0;
    if (state_q == SERVICE && (whatint_rd || rti_valid) && cause_q != 2'd0)
      pend_clr[cause_q - 2'd1] = 1'b1;
    pend_clr[1:0] = pend_clr[1:0] | (cmd_hit & ~cmd_load);
    pend_d = (pend_q & ~pend_clr) | {ext_edge, tick & ~cmd_hit};
  end
  // REQ aborts on the next-cycle pending view so a disable drops int_req one cycle later.
  always_comb begin
    cause_pend = (cause_q == 2'd1) ? pend_d[0] : (cause_q == 2'd2) ? pend_d[1] : pend_d[2];
    state_d    = state_q;
    cause_d    = cause_q;
    int_req    = 1'b0;
    in_service = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d = REQ;
          cause_d = pend_q[0] ? 2'd1 : pend_q[1] ? 2'd2 : 2'd3;
        end
      end
      REQ: begin
        int_req = 1'b1;
        if (int_ack) begin
          state_d = SERVICE;
        end else if (!cause_pend) begin
          state_d = IDLE;
          cause_d = 2'd0;
        end
      end
      SERVICE: begin
        in_service = 1'b1;
        if (rti_valid) begin
          state_d = IDLE;
          cause_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cause_q    <= '0;
      period_q   <= '0;
      count_q    <= '0;
      en_q       <= '0;
      pend_q     <= '0;
      sync_q     <= '0;
      ext_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      period_q   <= period_d;
      count_q    <= count_d;
      en_q       <= en_d;
      pend_q     <= pend_d;
      sync_q     <= sync_d;
      ext_prev_q <= ext_prev_d;
    end
  end
`ifdef CNT_INT_MISSED_EN
  logic [1:0][7:0] missed_q, missed_d;
  always_comb begin
    missed_d = missed_q;
    for (int i = 0; i < 2; i++) begin
      if (cmd_hit[i] || (state_q == SERVICE && whatint_rd && cause_q == 2'(i + 1)))
        missed_d[i] = '0;
      else if (tick[i] && pend_q[i] && missed_q[i] != 8'hff)
        missed_d[i] = missed_q[i] + 8'd1;
    end
    missed_sel = (cause_q == 2'd1) ? missed_q[0] : (cause_q == 2'd2) ? missed_q[1] : 8'd0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) missed_q <= '0;
    else missed_q <= missed_d;
  end
`else
  assign missed_sel = 8'd0;
`endif
  assign int_cause = {cause_q, 14'b0, missed_sel, 5'b0, pend_q};
endmodule

// File: doc/cnt_int_ctrl.md
Name: cnt_int_ctrl

Overview:
- Interrupt-source side of the counter-interrupt/`rti`/`whatint` instruction protocol that the CPU controller decodes.
- Accepts counter-interrupt commands issued from the E stage: load a period or disable a timer.
- Runs two programmable periodic timers and one external edge source, the light-gun trigger.
- Raises a single interrupt request to the pipeline, supplies the cause word read by the `whatint` instruction, and ends service on `rti`.

Parameters:
- CNT_W, 32, width of timer period and count registers.
- SYNC_STAGES, 2, synchronizer depth on `ext_int`.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset; block is in reset while 0.
- stallE  in  1  E-stage stall; a command is consumed only when `stallE` is 0.
- cnt_intE  in  1  counter-interrupt instruction in E.
- cnt_int_selE  in  1  timer select: 0 selects timer0, 1 selects timer1.
- cnt_int_disableE  in  1  command is disable (1) or load/enable (0).
- cnt_valE  in  CNT_W  period operand (rs value).
- ext_int  in  1  asynchronous external interrupt (gun trigger).
- int_ack  in  1  pipeline has taken the interrupt (PC redirected).
- rti_valid  in  1  `rti` retired; already qualified with the stall by the pipeline.
- whatint_rd  in  1  `whatint` instruction reading the cause this cycle.
- int_req  out  1  interrupt request to the pipeline.
- int_cause  out  32  cause word.
- in_service  out  1  handler currently running.

Behaviour:
- Reset (asynchronous, `reset`=0): clears all periods, counts, enables, pending bits and synchronizer flops; FSM goes to IDLE. Outputs: `int_req`=0, `in_service`=0, `int_cause`=0.
- Command accept condition: `cnt_intE` & ~`stallE`.
  - Disable: timer[sel] stops, count=0, pending[sel] cleared.
  - Load: period[sel]=`cnt_valE`, count=0, enable=1.
  - Load with `cnt_valE`=0 behaves exactly as disable.
- Timer run:
  - An enabled timer increments its count every cycle.
  - When count == period-1: count wraps to 0 and pending[sel] is set. The first tick occurs `period` cycles after the load cycle.
  - Pending is sticky; a tick while already pending is lost.
  - If a command to a timer and a tick of the same timer fall in the same cycle, the command wins.
- External source:
  - `ext_int` is synchronized through SYNC_STAGES flops.
  - A rising edge of the synchronized signal sets pending[2].
  - Level-held input sets pending once only.
- Priority: timer0 > timer1 > ext. Cause codes: 1, 2, 3 respectively; 0 means none.
- FSM states and transitions:
  - IDLE: `int_req`=0. If any pending, latch the highest-priority code into `cause_q` and go to REQ on the next cycle.
  - REQ: `int_req`=1 while in this state.
    - On `int_ack` go to SERVICE.
    - If the latched source is disabled or its pending bit is cleared before `int_ack`, go to IDLE and set `cause_q`=0. A lower-priority pending source is re-arbitrated from IDLE.
  - SERVICE: `int_req`=0, `in_service`=1.
    - `whatint_rd` clears pending[`cause_q`].
    - `rti_valid` clears pending[`cause_q`] if still set and goes to IDLE.
- `int_cause` = {16'b0, 8'b0 (see optional feature), 5'b0, pending[2:0]} in bits [15:0] with `cause_q` in [31:30]; exact mapping:
  - [31:30] = cause_q[1:0].
  - [2:0] = pending vector.
  - All other bits 0.
- Simultaneous `rti_valid` and new pending: FSM spends one cycle in IDLE, so `int_req` reasserts 2 cycles after `rti_valid`.
- `int_ack` outside REQ, `rti_valid` outside SERVICE, and `whatint_rd` outside SERVICE are ignored. `whatint_rd` outside SERVICE reads `int_cause` only.
- Timers keep counting in all FSM states.

Optional Feature:
- Macro: CNT_INT_MISSED_EN.
- When defined:
  - Each timer has an 8-bit saturating missed-tick counter. It increments on a tick that occurs while that timer's pending is already set, and saturates at 255.
  - `int_cause`[15:8] shows the missed count of the source in `cause_q`.
  - `whatint_rd` in SERVICE clears that counter; a load or disable command to the timer also clears it.
- When undefined: `int_cause`[15:8]=0 and no counter flops are present.

Test Plan:
- Reset low mid-count, period 5 loaded → all outputs 0 immediately (asynchronously); after release no `int_req` until a new load command.
- Load timer0 period 4, `stallE`=0 → `int_req`=1 within 6 cycles; `int_ack` → `in_service`=1; `whatint_rd` → `int_cause`[31:30]=1, [0] clears; `rti_valid` → IDLE; next tick 4 cycles after previous.
- Timer0 period 3 and timer1 period 3 loaded the same cycle (two consecutive commands), both pending → cause 1 serviced first, then after `rti_valid` `int_req` returns with cause 2.
- Command issued with `stallE`=1 for 3 cycles → no effect until the stall drops; disable timer1 while in REQ with cause 2 → `int_req` drops next cycle, cause 0.
- `ext_int` held high 20 cycles → exactly one pending[2] and one interrupt, cause 3; `rti_valid` in the same cycle as a timer0 tick → `int_req` 2 cycles later, cause 1.
- With CNT_INT_MISSED_EN: timer0 period 2, hold `int_ack` off 11 cycles → `int_cause`[15:8]=5; `whatint_rd` → 0. Without the macro → [15:8]=0.
